// File: rtl/change_dispenser.sv
// Greedy change dispenser: splits an amount into 50/10/5/1 coins and pays one
// coin per step period, with 7-segment readouts of the remaining amount and
// of the per-denomination coin counts.
module change_dispenser #(
  parameter int unsigned TICK_DIV   = 4000000,
  parameter int unsigned MAX_AMOUNT = 99
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [6:0] amount_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       coin_valid_o,
  output logic [5:0] coin_value_o,
  output logic [6:0] remaining_o,
  output logic [3:0] cnt50_o,
  output logic [3:0] cnt10_o,
  output logic [3:0] cnt5_o,
  output logic [3:0] cnt1_o,
  output logic [6:0] seg5_o,
  output logic [6:0] seg4_o,
  output logic [6:0] seg3_o,
  output logic [6:0] seg2_o,
  output logic [6:0] seg1_o,
  output logic [6:0] seg0_o
);

  localparam int unsigned DIV_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPENSE,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [6:0]       rem_q;
  logic [6:0]       rem_d;
  logic [3:0]       cnt50_q, cnt10_q, cnt5_q, cnt1_q;
  logic [5:0]       coin_value_q;
  logic [5:0]       coin_sel;
  logic             coin_valid_q;
  logic             busy_q, done_q, err_q;
  logic             amount_ok;
  logic             step;
  logic [3:0]       rem_tens, rem_ones;

  // Active-low segment pattern (gfedcba) for one BCD digit; non-digits blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0011000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign amount_ok = (amount_i != 7'd0) && (amount_i <= 7'(MAX_AMOUNT));
  assign step      = (div_cnt_q == DIV_W'(TICK_DIV));

  // Greedy choice of the next coin from what is still owed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    coin_sel = 6'd1;
    if (rem_q >= 7'd50)      coin_sel = 6'd50;
    else if (rem_q >= 7'd10) coin_sel = 6'd10;
    else if (rem_q >= 7'd5)  coin_sel = 6'd5;
    rem_d = rem_q - {1'b0, coin_sel};
  end

  // Control FSM with its datapath registers and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      rem_q        <= '0;
      cnt50_q      <= '0;
      cnt10_q      <= '0;
      cnt5_q       <= '0;
      cnt1_q       <= '0;
      coin_value_q <= '0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      coin_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            if (amount_ok) begin
              err_q     <= 1'b0;
              rem_q     <= amount_i;
              cnt50_q   <= '0;
              cnt10_q   <= '0;
              cnt5_q    <= '0;
              cnt1_q    <= '0;
              div_cnt_q <= '0;
              state_q   <= S_DISPENSE;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_DISPENSE: begin
          if (step) begin
            div_cnt_q    <= '0;
            rem_q        <= rem_d;
            coin_value_q <= coin_sel;
            coin_valid_q <= 1'b1;
            case (coin_sel)
              6'd50:   cnt50_q <= cnt50_q + 4'd1;
              6'd10:   cnt10_q <= cnt10_q + 4'd1;
              6'd5:    cnt5_q  <= cnt5_q + 4'd1;
              default: cnt1_q  <= cnt1_q + 4'd1;
            endcase
            if (rem_d == 7'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rem_tens = 4'(rem_q / 7'd10);
  assign rem_ones = 4'(rem_q % 7'd10);

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign coin_valid_o = coin_valid_q;
  assign coin_value_o = coin_value_q;
  assign remaining_o  = rem_q;
  assign cnt50_o      = cnt50_q;
  assign cnt10_o      = cnt10_q;
  assign cnt5_o       = cnt5_q;
  assign cnt1_o       = cnt1_q;
  assign seg5_o       = seg7(rem_tens);
  assign seg4_o       = seg7(rem_ones);
  assign seg3_o       = seg7(cnt50_q);
  assign seg2_o       = seg7(cnt10_q);
  assign seg1_o       = seg7(cnt5_q);
  assign seg0_o       = seg7(cnt1_q);

endmodule
